// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port RAM.
// One transaction in flight; outputs are registered.
module mem_arbiter #(
   parameter int unsigned DEPTH        = 256,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        err0,
   output logic        err1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        mem_en,
   output logic        mem_rw,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_a,
   input  logic [15:0] mem_q,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [16:0] DEPTH_W = 17'(DEPTH);
   localparam logic [2:0]  LAT_W   = 3'(READ_LATENCY);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        id_q, id_d;
   logic        we_q, we_d;
   logic        oor_q, oor_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wd_q, wd_d;
   logic [2:0]  cnt_q, cnt_d;

   logic        win;
   logic        w_we;
   logic [15:0] w_addr, w_wd;
   logic        fin, fin_id, fin_err, cap;

   logic        ack0_d, ack1_d, err0_d, err1_d;
   logic [15:0] rdata0_d, rdata1_d;
   logic        mem_en_d, mem_rw_d, busy_d;
   logic [15:0] mem_addr_d, mem_a_d;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      id_d       = id_q;
      we_d       = we_q;
      oor_d      = oor_q;
      addr_d     = addr_q;
      wd_d       = wd_q;
      cnt_d      = cnt_q;
      win        = 1'b0;
      w_we       = 1'b0;
      w_addr     = 16'h0000;
      w_wd       = 16'h0000;
      fin        = 1'b0;
      fin_id     = id_q;
      fin_err    = 1'b0;
      cap        = 1'b0;
      mem_en_d   = 1'b0;
      mem_rw_d   = mem_rw;
      mem_addr_d = mem_addr;
      mem_a_d    = mem_a;

      unique case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // A tie goes to whoever did not win the previous tie
               win    = (req0 && req1) ? ~last_q : req1;
               w_we   = win ? we1 : we0;
               w_addr = win ? addr1 : addr0;
               w_wd   = win ? wdata1 : wdata0;
               if (req0 && req1) last_d = win;
               id_d   = win;
               we_d   = w_we;
               addr_d = w_addr;
               wd_d   = w_wd;
               oor_d  = {1'b0, w_addr} >= DEPTH_W;
               if (oor_d) begin
                  state_d = DONE;
                  fin     = 1'b1;
                  fin_id  = win;
                  fin_err = 1'b1;
               end else begin
                  state_d    = ISSUE;
                  mem_en_d   = 1'b1;
                  mem_rw_d   = ~w_we;
                  mem_addr_d = w_addr;
                  mem_a_d    = w_wd;
               end
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = DONE;
               fin     = 1'b1;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_W;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = DONE;
               fin     = 1'b1;
               cap     = 1'b1;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ack0_d   = fin && !fin_id;
      ack1_d   = fin && fin_id;
      err0_d   = fin_err && !fin_id;
      err1_d   = fin_err && fin_id;
      rdata0_d = (cap && !id_q) ? mem_q : rdata0;
      rdata1_d = (cap && id_q) ? mem_q : rdata1;
      busy_d   = state_d != IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         oor_q    <= 1'b0;
         addr_q   <= 16'h0000;
         wd_q     <= 16'h0000;
         cnt_q    <= 3'd0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         err0     <= 1'b0;
         err1     <= 1'b0;
         rdata0   <= 16'h0000;
         rdata1   <= 16'h0000;
         mem_en   <= 1'b0;
         mem_rw   <= 1'b1;
         mem_addr <= 16'h0000;
         mem_a    <= 16'h0000;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         we_q     <= we_d;
         oor_q    <= oor_d;
         addr_q   <= addr_d;
         wd_q     <= wd_d;
         cnt_q    <= cnt_d;
         ack0     <= ack0_d;
         ack1     <= ack1_d;
         err0     <= err0_d;
         err1     <= err1_d;
         rdata0   <= rdata0_d;
         rdata1   <= rdata1_d;
         mem_en   <= mem_en_d;
         mem_rw   <= mem_rw_d;
         mem_addr <= mem_addr_d;
         mem_a    <= mem_a_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: timeline model for READ_LATENCY=1 plus
// directed checks, and a second instance at READ_LATENCY=3.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        req [2];
   logic        we [2];
   logic [15:0] addr [2];
   logic [15:0] wdata [2];
   logic        ack0, ack1, err0, err1, mem_en, mem_rw, busy;
   logic [15:0] rdata0, rdata1, mem_addr, mem_a, mem_q;

   mem_arbiter #(.DEPTH(256), .READ_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]),
      .we0(we[0]), .we1(we[1]),
      .addr0(addr[0]), .addr1(addr[1]),
      .wdata0(wdata[0]), .wdata1(wdata[1]),
      .ack0(ack0), .ack1(ack1),
      .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_rw(mem_rw),
      .mem_addr(mem_addr), .mem_a(mem_a),
      .mem_q(mem_q), .busy(busy)
   );

   // RAM for the latency-1 instance
   logic [15:0] ram [256];
   logic [15:0] ram_q = 16'h0000;
   always @(posedge clk) begin
      if (mem_en) begin
         if (!mem_rw) ram[mem_addr[7:0]] <= mem_a;
         else ram_q <= ram[mem_addr[7:0]];
      end
   end
   assign mem_q = ram_q;

   // Second instance, READ_LATENCY=3, port 1 idle
   logic        b_req0 = 1'b0;
   logic [15:0] b_addr0 = 16'h0000;
   logic        b_ack0, b_ack1, b_err0, b_err1, b_en, b_rw, b_busy;
   logic [15:0] b_rdata0, b_rdata1, b_maddr, b_ma, b_q;

   mem_arbiter #(.DEPTH(256), .READ_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0(b_req0), .req1(1'b0),
      .we0(1'b0), .we1(1'b0),
      .addr0(b_addr0), .addr1(16'h0000),
      .wdata0(16'h0000), .wdata1(16'h0000),
      .ack0(b_ack0), .ack1(b_ack1),
      .err0(b_err0), .err1(b_err1),
      .rdata0(b_rdata0), .rdata1(b_rdata1),
      .mem_en(b_en), .mem_rw(b_rw),
      .mem_addr(b_maddr), .mem_a(b_ma),
      .mem_q(b_q), .busy(b_busy)
   );

   logic [15:0] b_ram [256];
   logic [15:0] b_p0 = 16'h0000, b_p1 = 16'h0000, b_p2 = 16'h0000;
   always @(posedge clk) begin
      if (b_en && b_rw) b_p0 <= b_ram[b_maddr[7:0]];
      b_p1 <= b_p0;
      b_p2 <= b_p1;
   end
   assign b_q = b_p2;

   // Behavioural model: position within the current transaction's timeline
   logic [15:0] ref_mem [256];
   int          m_pos = 0;
   int          m_len = 0;
   bit          m_id = 1'b0, m_we = 1'b0, m_oor = 1'b0, m_last = 1'b1;
   logic [15:0] m_addr = 16'h0, m_wd = 16'h0;
   logic [15:0] e_rd [2];
   logic        e_rw = 1'b1;
   logic [15:0] e_maddr = 16'h0, e_ma = 16'h0;

   always @(posedge clk) begin
      if (rst) begin
         m_pos = 0;
         m_last = 1'b1;
         e_rd[0] = 16'h0;
         e_rd[1] = 16'h0;
         e_rw = 1'b1;
         e_maddr = 16'h0;
         e_ma = 16'h0;
      end else begin
         if (m_pos == 0) begin
            if (req[0] || req[1]) begin
               if (req[0] && req[1]) begin
                  m_id = ~m_last;
                  m_last = m_id;
               end else m_id = req[1];
               m_we = we[m_id];
               m_addr = addr[m_id];
               m_wd = wdata[m_id];
               m_oor = m_addr >= 16'd256;
               m_len = m_oor ? 1 : (m_we ? 2 : 3);
               m_pos = 1;
            end
         end else if (m_pos == m_len) m_pos = 0;
         else m_pos = m_pos + 1;
         if (m_pos == 1 && !m_oor) begin
            e_rw = ~m_we;
            e_maddr = m_addr;
            e_ma = m_wd;
            if (m_we) ref_mem[m_addr[7:0]] = m_wd;
         end
         if (m_pos != 0 && m_pos == m_len && !m_we && !m_oor)
            e_rd[m_id] = ref_mem[m_addr[7:0]];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   bit chk_on = 1'b0;
   int ord [$];
   logic e_fin;

   always @(negedge clk) begin
      if (chk_on) begin
         e_fin = m_pos != 0 && m_pos == m_len;
         chk("busy", busy, m_pos != 0);
         chk("mem_en", mem_en, m_pos == 1 && !m_oor);
         chk("ack0", ack0, e_fin && !m_id);
         chk("ack1", ack1, e_fin && m_id);
         chk("err0", err0, e_fin && !m_id && m_oor);
         chk("err1", err1, e_fin && m_id && m_oor);
         chk("rdata0", rdata0, e_rd[0]);
         chk("rdata1", rdata1, e_rd[1]);
         chk("mem_rw", mem_rw, e_rw);
         chk("mem_addr", mem_addr, e_maddr);
         chk("mem_a", mem_a, e_ma);
         if (ack0) ord.push_back(0);
         if (ack1) ord.push_back(1);
      end
   end

   task automatic txn(input int p, input logic w, input logic [15:0] a,
                      input logic [15:0] d, output int lat);
      logic got;
      req[p] = 1'b1;
      we[p] = w;
      addr[p] = a;
      wdata[p] = d;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         got = p ? ack1 : ack0;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL timeout port%0d actual=no_ack expected=ack", p);
      end
      req[p] = 1'b0;
      @(negedge clk);
   endtask

   int lat, lat0, lat1, n, waits;
   logic got;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = {i[7:0], ~i[7:0]};
         ref_mem[i] = {i[7:0], ~i[7:0]};
         b_ram[i] = 16'h0000;
      end
      b_ram[0] = 16'h1234;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0;
         we[i] = 1'b0;
         addr[i] = 16'h0;
         wdata[i] = 16'h0;
      end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_rw", mem_rw, 1'b1);
      chk("rst_busy", busy, 1'b0);
      rst = 1'b0;
      @(negedge clk);

      txn(0, 1'b1, 16'h0010, 16'hBEEF, lat);
      chk("wr_lat", lat, 2);
      txn(0, 1'b0, 16'h0010, 16'h0000, lat);
      chk("rd_lat", lat, 3);
      chk("rd_data0", rdata0, 16'hBEEF);
      chk("rd_data1", rdata1, 16'h0000);

      ord.delete();
      fork
         for (int k = 0; k < 4; k++) txn(0, 1'b0, 16'h0020 + 16'(k), 16'h0, lat0);
         for (int k = 0; k < 4; k++) txn(1, 1'b0, 16'h0040 + 16'(k), 16'h0, lat1);
      join
      chk("rr_count", ord.size(), 8);
      for (int k = 0; k < 8 && k < ord.size(); k++)
         chk("rr_order", ord[k], k % 2);
      chk("rr_last1", rdata1, 16'h43BC);

      txn(1, 1'b0, 16'h0100, 16'h0, lat);
      chk("oor_lat", lat, 1);
      chk("oor_rdata1", rdata1, 16'h43BC);

      req[1] = 1'b1;
      we[1] = 1'b0;
      addr[1] = 16'h0005;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      req[1] = 1'b0;
      @(negedge clk);
      chk("mid_rst_ack1", ack1, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_en", mem_en, 1'b0);
      chk("mid_rst_rd0", rdata0, 16'h0000);
      rst = 1'b0;
      txn(0, 1'b0, 16'h0033, 16'h0, lat);
      chk("post_rst_lat", lat, 3);
      chk("post_rst_rd0", rdata0, 16'h33CC);

      b_req0 = 1'b1;
      b_addr0 = 16'h0000;
      n = 0;
      waits = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (b_ack0) got = 1'b1;
         else if (b_busy && !b_en) waits++;
      end
      b_req0 = 1'b0;
      chk("l3_lat", n, 5);
      chk("l3_waits", waits, 3);
      chk("l3_rdata0", b_rdata0, 16'h1234);
      chk("l3_err0", b_err0, 1'b0);
      @(negedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 256x16 single-port RAM.
- Requester 0 is the instruction fetch unit; requester 1 is the load/store unit.
- Accepts one transaction at a time and grants round-robin when both request.
- Drives the RAM's en/rw/addr/data pins, captures read data after the fixed RAM latency, and returns a one-cycle ack with data or an error flag.

Parameters:
- DEPTH, 256, number of implemented RAM words; any address >= DEPTH is out of range.
- READ_LATENCY, 1, cycles from the mem_en cycle until mem_q holds valid read data (range 1-7).

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  transaction request from requester 0 / 1.
- we0, we1  in  1  1 = write, 0 = read.
- addr0, addr1  in  16  word address.
- wdata0, wdata1  in  16  write data.
- ack0, ack1  out  1  one-cycle completion pulse.
- err0, err1  out  1  valid with ack; 1 = address out of range.
- rdata0, rdata1  out  16  read data, valid with ack on a read, held until that port's next read completes.
- mem_en  out  1  RAM enable.
- mem_rw  out  1  RAM direction: 1 = read, 0 = write.
- mem_addr  out  16  RAM address.
- mem_a  out  16  RAM write data.
- mem_q  in  16  RAM read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: state IDLE, last_grant = 1 (so requester 0 wins the first tie).
  - Outputs: ack*, err*, mem_en, busy = 0; mem_rw = 1; mem_addr, mem_a, rdata* = 16'h0000.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: pick the winner.
  - Only one req high: that requester wins.
  - Both high: the requester other than last_grant wins; last_grant is updated to the winner.
  - Latch the winner's we, addr, wdata and id.
  - If addr >= DEPTH: go to DONE with err set; the RAM is never enabled.
  - Otherwise: go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en = 1; mem_rw = ~we; mem_addr = latched addr; mem_a = latched wdata.
  - Write: go to DONE.
  - Read: load the latency counter with READ_LATENCY and go to WAIT.
- WAIT:
  - mem_en = 0; mem_addr and mem_rw hold their values.
  - Decrement the counter; at 0, capture mem_q into the winner's rdata and go to DONE.
- DONE (exactly 1 cycle): ack of the winner = 1; err = out-of-range flag; next state IDLE.
- Latency from req seen in IDLE to ack, with READ_LATENCY=1:
  - write: 2 cycles.
  - read: 3 cycles.
  - out-of-range access: 1 cycle.
- Handshake rules:
  - Requester holds req, we, addr and wdata stable until ack.
  - Requester drops req in the cycle after ack.
  - req is sampled only in IDLE.
  - A req that drops mid-transaction does not abort it; ack still pulses.
- Requests arriving while busy wait; nothing is queued beyond the req level.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1.
- The non-winning port's outputs are untouched: ack = 0, rdata held.
- err is cleared (to 0) in every cycle other than the DONE cycle.
- rst mid-transaction: the next edge forces the reset state.
  - The in-flight transaction is dropped; no ack is issued.
  - mem_en is low from that edge onward.
  - A write already issued in ISSUE is not rolled back.
- Address width rule: the full 16-bit address is compared against DEPTH and passed unmodified to mem_addr; there is no wrap.

Test Plan:
- Reset, then req0 write addr 16'h0010 data 16'hBEEF -> mem_en high for 1 cycle with mem_rw=0, mem_addr=0x0010, mem_a=0xBEEF; ack0 two cycles after req; err0=0.
- After that write, req0 read addr 0x0010 (RAM model, READ_LATENCY=1) -> ack0 three cycles after req; rdata0=0xBEEF; rdata1 unchanged at 0x0000.
- req0 and req1 both held high for 4 reads each -> ack order 0,1,0,1,... with no port granted twice in a row; busy stays high except one IDLE cycle between transactions.
- req1 read addr 0x0100 (DEPTH=256) -> ack1 and err1 high one cycle after req; mem_en never asserted; rdata1 unchanged.
- req1 read addr 0x0005; rst asserted during WAIT -> no ack1; state IDLE and all outputs at reset values after the edge; a subsequent req0 read completes normally.
- READ_LATENCY=3, req0 read addr 0x0000 preloaded 0x1234 -> exactly 3 WAIT cycles; ack0 five cycles after req; rdata0=0x1234.
